spi_txn_sched: RTL and testbench
================================

SPI_TXN_SCHED -- requirements
Module: spi_txn_sched

Interface
REQ-001 Parameter GAP_CYCLES, default 4, meaning idle cycles enforced between transactions, with spi_ss deasserted; legal range 1..255.
REQ-002 Parameter TIMEOUT, default 1023, meaning the maximum cycles allowed in WAIT_BUSY plus XFER before aborting; legal range 2..65535.
REQ-003 Port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port req0, input, 1 bit: requester 0 transaction request; held high until gnt0.
REQ-006 Port data0, input, 8 bits: requester 0 byte to send; valid while req0 is high.
REQ-007 Port req1, input, 1 bit: requester 1 transaction request; held high until gnt1.
REQ-008 Port data1, input, 8 bits: requester 1 byte to send.
REQ-009 Port gnt0 and gnt1, output, 1 bit each: one-cycle grant pulses.
REQ-010 Port rsp_valid, output, 1 bit: one-cycle response strobe.
REQ-011 Port rsp_id, output, 1 bit: index of the requester that owns the response.
REQ-012 Port rsp_data, output, 8 bits: byte received from the SPI master.
REQ-013 Port rsp_err, output, 1 bit: timeout flag, qualified by rsp_valid.
REQ-014 Port spi_ss, output, 1 bit: slave select, active-low, idle high.
REQ-015 Port spi_data, output, 8 bits: byte presented to the SPI master.
REQ-016 Port spi_start, output, 1 bit: one-cycle start pulse to the SPI master.
REQ-017 Port spi_busy, input, 1 bit: SPI master busy.
REQ-018 Port spi_rx, input, 8 bits: SPI master received byte; valid when spi_busy falls.

Function
REQ-019 The FSM SHALL have states IDLE, START, WAIT_BUSY, XFER, DONE and GAP; all outputs are registered.
REQ-020 In IDLE with any req high at edge k, the block SHALL select the winner, pulse its gnt, latch its data into spi_data, record rsp_id, drive spi_ss=0 and enter START, all at edge k.
REQ-021 Arbitration SHALL be round-robin on a last_id register: when both requesters are high, the one not equal to last_id wins.
REQ-022 When exactly one requester is high, that requester wins; last_id SHALL update to the winner on every grant.
REQ-023 START SHALL last exactly one cycle with spi_start=1, then enter WAIT_BUSY with spi_start=0.
REQ-024 WAIT_BUSY SHALL wait for spi_busy=1, then enter XFER.
REQ-025 XFER SHALL wait for spi_busy=0, then capture spi_rx into rsp_data and enter DONE.
REQ-026 DONE SHALL last one cycle, with rsp_valid=1, rsp_err=0 and spi_ss returned to 1.
REQ-027 Timeout: a 16-bit counter SHALL clear on entering WAIT_BUSY and increment each cycle in WAIT_BUSY and XFER.
REQ-028 When the timeout counter reaches TIMEOUT, the block SHALL enter DONE with rsp_err=1 and rsp_data=0x00.
REQ-029 If the timeout count is reached on the same edge as the busy edge that completes the transaction, normal completion SHALL win.
REQ-030 GAP SHALL hold spi_ss=1 for exactly GAP_CYCLES cycles, then enter IDLE; requests arriving during any non-IDLE state wait, with no grant and no loss.
REQ-031 Minimum request-to-request throughput SHALL be 1 (grant) + 1 (START) + transfer + 1 (DONE) + GAP_CYCLES cycles.
REQ-032 rsp_id SHALL remain stable from the grant through DONE.

Reset
REQ-033 rst high at a clock edge SHALL force: state=IDLE, gnt0=gnt1=0, rsp_valid=0, rsp_err=0, rsp_id=0, rsp_data=0x00, spi_ss=1, spi_start=0, spi_data=0x00, last_id=1, counters=0.
REQ-034 Reset mid-transaction SHALL abandon the transaction with no rsp_valid; the first grant after release SHALL go to req0 if both requesters are high.

Verification
REQ-035 Single request: req0=1, data0=0xA5; SPI model asserts busy 2 cycles after start for 16 cycles and returns 0x3C -> gnt0 at edge 1, spi_start at edge 2, rsp_valid with rsp_id=0, rsp_data=0x3C, rsp_err=0, then spi_ss high for 4 cycles.
REQ-036 Contention: req0 and req1 held high for 3 transactions -> grant order 0, 1, 0, and rsp_id matches each grant.
REQ-037 Timeout: TIMEOUT=20, spi_busy held 0 -> rsp_valid at the 20th count with rsp_err=1, rsp_data=0x00, and spi_ss=1.
REQ-038 Late request: req1 rises during XFER of requester 0 -> gnt1 only on the first IDLE cycle after GAP, with no duplicate grant.
REQ-039 Mid-transfer reset: rst pulsed in XFER -> all outputs at their REQ-033 values the next cycle, no rsp_valid, and the next contention is won by req0.
REQ-040 Tie: timeout count reached on the same edge as spi_busy falls -> rsp_err=0 and rsp_data=spi_rx.

Source files
------------

// File: rtl/spi_txn_sched.sv
// Two-requester SPI transaction scheduler: round-robin grant, one byte per
// transaction, busy-handshake with the SPI master, timeout and inter-transaction gap.
module spi_txn_sched #(
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] data0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       spi_ss,
    output logic [7:0] spi_data,
    output logic       spi_start,
    input  logic       spi_busy,
    input  logic [7:0] spi_rx
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned GAP_W = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WAIT_BUSY, S_XFER, S_DONE, S_GAP
    } state_t;

    state_t             r_state, w_state;
    logic               r_gnt0, w_gnt0;
    logic               r_gnt1, w_gnt1;
    logic               r_valid, w_valid;
    logic               r_id, w_id;
    logic [7:0]         r_rdata, w_rdata;
    logic               r_err, w_err;
    logic               r_ss, w_ss;
    logic [7:0]         r_sdata, w_sdata;
    logic               r_start, w_start;
    logic               r_last, w_last;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic [GAP_W-1:0]   r_gap, w_gap;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [GAP_W-1:0]   w_gap_inc;
    logic               w_win;

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_gap_inc = r_gap + GAP_W'(1);
    // Both requesting: the one that did not win last; otherwise whoever is asking.
    assign w_win     = (req0 & req1) ? ~r_last : ~req0;

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign rsp_valid = r_valid;
    assign rsp_id    = r_id;
    assign rsp_data  = r_rdata;
    assign rsp_err   = r_err;
    assign spi_ss    = r_ss;
    assign spi_data  = r_sdata;
    assign spi_start = r_start;

    // Next-state and next-output decode; pulses default low, held values default to hold.
    always_comb begin
        w_state = r_state;
        w_gnt0  = 1'b0;
        w_gnt1  = 1'b0;
        w_valid = 1'b0;
        w_start = 1'b0;
        w_id    = r_id;
        w_rdata = r_rdata;
        w_err   = r_err;
        w_ss    = r_ss;
        w_sdata = r_sdata;
        w_last  = r_last;
        w_cnt   = r_cnt;
        w_gap   = r_gap;
        case (r_state)
            S_IDLE: begin
                if (req0 | req1) begin
                    w_gnt0  = ~w_win;
                    w_gnt1  = w_win;
                    w_sdata = w_win ? data1 : data0;
                    w_id    = w_win;
                    w_last  = w_win;
                    w_ss    = 1'b0;
                    w_state = S_START;
                end
            end
            S_START: begin
                w_start = 1'b1;
                w_cnt   = '0;
                w_state = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                w_cnt = w_cnt_inc;
                if (w_cnt_inc == CNT_W'(TIMEOUT)) begin
                    w_valid = 1'b1;
                    w_err   = 1'b1;
                    w_rdata = 8'h00;
                    w_ss    = 1'b1;
                    w_state = S_DONE;
                end else if (spi_busy) begin
                    w_state = S_XFER;
                end
            end
            S_XFER: begin
                w_cnt = w_cnt_inc;
                // Completion takes priority over a timeout on the same edge.
                if (!spi_busy) begin
                    w_valid = 1'b1;
                    w_err   = 1'b0;
                    w_rdata = spi_rx;
                    w_ss    = 1'b1;
                    w_state = S_DONE;
                end else if (w_cnt_inc == CNT_W'(TIMEOUT)) begin
                    w_valid = 1'b1;
                    w_err   = 1'b1;
                    w_rdata = 8'h00;
                    w_ss    = 1'b1;
                    w_state = S_DONE;
                end
            end
            S_DONE: begin
                w_gap   = '0;
                w_state = S_GAP;
            end
            S_GAP: begin
                w_gap = w_gap_inc;
                if (w_gap_inc == GAP_W'(GAP_CYCLES)) begin
                    w_state = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_valid <= 1'b0;
            r_id    <= 1'b0;
            r_rdata <= 8'h00;
            r_err   <= 1'b0;
            r_ss    <= 1'b1;
            r_sdata <= 8'h00;
            r_start <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_state;
            r_gnt0  <= w_gnt0;
            r_gnt1  <= w_gnt1;
            r_valid <= w_valid;
            r_id    <= w_id;
            r_rdata <= w_rdata;
            r_err   <= w_err;
            r_ss    <= w_ss;
            r_sdata <= w_sdata;
            r_start <= w_start;
            r_last  <= w_last;
            r_cnt   <= w_cnt;
            r_gap   <= w_gap;
        end
    end

endmodule

// File: tb/tb_spi_txn_sched.sv
// Self-checking bench for spi_txn_sched: cycle-accurate reference model compared
// every cycle, plus hand-computed timing/ordering expectations.
module tb_spi_txn_sched;

    localparam int GAP = 4;
    localparam int TO  = 20;

    logic       clk = 1'b0;
    logic       rst, req0, req1, spi_busy;
    logic [7:0] data0, data1, spi_rx;
    logic       gnt0, gnt1, rsp_valid, rsp_id, rsp_err, spi_ss, spi_start;
    logic [7:0] rsp_data, spi_data;

    always #5 clk = ~clk;

    spi_txn_sched #(.GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .spi_ss(spi_ss), .spi_data(spi_data), .spi_start(spi_start),
        .spi_busy(spi_busy), .spi_rx(spi_rx)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // ---------------- reference model (transaction timeline) ----------------
    localparam int P_IDLE = 0, P_START = 1, P_WAIT = 2, P_XFER = 3, P_DONE = 4, P_GAP = 5;
    int   cyc = 0;
    int   ph = P_IDLE, m_last = 1, m_cnt = 0, m_gap = 0, w;
    bit   model_on = 0;
    logic e_gnt0 = 0, e_gnt1 = 0, e_start = 0, e_valid = 0, e_err = 0, e_id = 0, e_ss = 1;
    logic [7:0] e_rdata = 0, e_sdata = 0;

    always @(posedge clk) begin
        cyc++;
        e_gnt0 = 0; e_gnt1 = 0; e_start = 0; e_valid = 0;
        if (rst) begin
            ph = P_IDLE; m_last = 1; m_cnt = 0; m_gap = 0;
            e_err = 0; e_id = 0; e_rdata = 0; e_ss = 1; e_sdata = 0;
            model_on = 1;
        end else begin
            case (ph)
                P_IDLE: if (req0 || req1) begin
                    w = (req0 && req1) ? 1 - m_last : (req0 ? 0 : 1);
                    if (w == 0) begin e_gnt0 = 1; e_sdata = data0; end
                    else        begin e_gnt1 = 1; e_sdata = data1; end
                    e_id = w[0]; m_last = w; e_ss = 0; ph = P_START;
                end
                P_START: begin e_start = 1; m_cnt = 0; ph = P_WAIT; end
                P_WAIT: begin
                    m_cnt++;
                    if (m_cnt == TO) begin e_valid = 1; e_err = 1; e_rdata = 0; e_ss = 1; ph = P_DONE; end
                    else if (spi_busy) ph = P_XFER;
                end
                P_XFER: begin
                    m_cnt++;
                    if (!spi_busy) begin e_valid = 1; e_err = 0; e_rdata = spi_rx; e_ss = 1; ph = P_DONE; end
                    else if (m_cnt == TO) begin e_valid = 1; e_err = 1; e_rdata = 0; e_ss = 1; ph = P_DONE; end
                end
                P_DONE: begin m_gap = 0; ph = P_GAP; end
                P_GAP: begin m_gap++; if (m_gap == GAP) ph = P_IDLE; end
                default: ph = P_IDLE;
            endcase
        end
    end

    // ---------------- per-cycle compare and event logging ----------------
    int gq[$], gcyc[$], scyc[$], vcyc[$], vid[$], verr[$], vdata[$], vss[$];

    always @(negedge clk) begin
        if (model_on) begin
            chk($sformatf("cyc%0d {gnt0,gnt1,vld,id,err,ss,start,rdata,sdata}", cyc),
                32'({gnt0, gnt1, rsp_valid, rsp_id, rsp_err, spi_ss, spi_start, rsp_data, spi_data}),
                32'({e_gnt0, e_gnt1, e_valid, e_id, e_err, e_ss, e_start, e_rdata, e_sdata}));
            if (gnt0) begin gq.push_back(0); gcyc.push_back(cyc); end
            if (gnt1) begin gq.push_back(1); gcyc.push_back(cyc); end
            if (spi_start) scyc.push_back(cyc);
            if (rsp_valid) begin
                vcyc.push_back(cyc); vid.push_back(int'(rsp_id)); verr.push_back(int'(rsp_err));
                vdata.push_back(int'(rsp_data)); vss.push_back(int'(spi_ss));
            end
        end
    end

    // ---------------- requesters: hold req until the wanted number of grants ----------------
    int pend0 = 0, pend1 = 0;
    always @(negedge clk) begin
        if (gnt0 && pend0 > 0) begin pend0--; if (pend0 == 0) req0 = 0; end
        if (gnt1 && pend1 > 0) begin pend1--; if (pend1 == 0) req1 = 0; end
    end

    // ---------------- SPI master responder ----------------
    bit         sp_on  = 1;
    int         sp_len = 16;
    logic [7:0] sp_rx  = 8'h3C;
    initial begin
        forever begin
            @(negedge clk);
            if (spi_start && sp_on) begin
                @(negedge clk);
                spi_busy = 1;
                repeat (sp_len) @(negedge clk);
                spi_rx   = sp_rx;
                spi_busy = 0;
            end
        end
    end

    task automatic wait_grants(input int n, input string nm);
        int k = 0;
        while (gq.size() < n && k < 400) begin @(negedge clk); k++; end
        if (gq.size() < n) chk(nm, 32'(gq.size()), 32'(n));
    endtask

    task automatic wait_valids(input int n, input string nm);
        int k = 0;
        while (vcyc.size() < n && k < 400) begin @(negedge clk); k++; end
        if (vcyc.size() < n) chk(nm, 32'(vcyc.size()), 32'(n));
    endtask

    int g, v, t;

    initial begin
        rst = 1; req0 = 0; req1 = 0; data0 = 0; data1 = 0; spi_busy = 0; spi_rx = 0;
        repeat (3) @(negedge clk);
        chk("reset spi_ss", 32'(spi_ss), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 0;
        @(negedge clk);

        // Contention from reset: order 0,1,0, one transaction every 25 cycles.
        data0 = 8'h11; data1 = 8'h22; sp_rx = 8'h3C; sp_len = 16;
        pend0 = 2; pend1 = 1; req0 = 1; req1 = 1;
        wait_grants(3, "contention grants");
        wait_valids(3, "contention responses");
        if (gq.size() >= 3 && vcyc.size() >= 3) begin
            chk("contention order 0", 32'(gq[0]), 32'd0);
            chk("contention order 1", 32'(gq[1]), 32'd1);
            chk("contention order 2", 32'(gq[2]), 32'd0);
            chk("rsp_id txn1", 32'(vid[1]), 32'd1);
            chk("rsp_id txn2", 32'(vid[2]), 32'd0);
            chk("grant spacing", 32'(gcyc[1] - gcyc[0]), 32'd25);
        end
        repeat (8) @(negedge clk);

        // Single request: gnt at edge 1, start at edge 2, response 19 edges after grant.
        g = gq.size(); v = vcyc.size(); t = cyc;
        data0 = 8'hA5; pend0 = 1; req0 = 1;
        wait_valids(v + 1, "single response");
        if (vcyc.size() > v && gq.size() > g) begin
            chk("single gnt edge", 32'(gcyc[g] - t), 32'd1);
            chk("single start edge", 32'(scyc[scyc.size()-1] - t), 32'd2);
            chk("single rsp edge", 32'(vcyc[v] - t), 32'd20);
            chk("single rsp_data", 32'(vdata[v]), 32'h3C);
            chk("single rsp_err", 32'(verr[v]), 32'd0);
            chk("single spi_data", 32'(spi_data), 32'hA5);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("gap spi_ss", 32'(spi_ss), 32'd1);
        end
        repeat (4) @(negedge clk);

        // Late request arriving during XFER of requester 0.
        g = gq.size(); v = vcyc.size();
        data0 = 8'h5A; data1 = 8'hC3; sp_rx = 8'h77; pend0 = 1; req0 = 1;
        t = 0;
        while (!spi_busy && t < 100) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        pend1 = 1; req1 = 1;
        wait_grants(g + 2, "late grant");
        repeat (40) @(negedge clk);
        chk("late grant count", 32'(gq.size() - g), 32'd2);
        if (gq.size() >= g + 2) begin
            chk("late grant id", 32'(gq[g+1]), 32'd1);
            chk("late grant edge", 32'(gcyc[g+1] - gcyc[g]), 32'd25);
        end

        // Timeout with no busy at all: response 21 edges after grant, err set.
        g = gq.size(); v = vcyc.size();
        sp_on = 0; pend1 = 1; req1 = 1;
        wait_valids(v + 1, "timeout response");
        if (vcyc.size() > v && gq.size() > g) begin
            chk("timeout edge", 32'(vcyc[v] - gcyc[g]), 32'd21);
            chk("timeout err", 32'(verr[v]), 32'd1);
            chk("timeout data", 32'(vdata[v]), 32'd0);
            chk("timeout ss", 32'(vss[v]), 32'd1);
        end
        repeat (10) @(negedge clk);

        // Tie: busy falls on the 20th count edge -> normal completion.
        sp_on = 1; sp_len = 18; sp_rx = 8'h9E;
        v = vcyc.size(); pend0 = 1; req0 = 1;
        wait_valids(v + 1, "tie response");
        if (vcyc.size() > v) begin
            chk("tie err", 32'(verr[v]), 32'd0);
            chk("tie data", 32'(vdata[v]), 32'h9E);
        end
        repeat (10) @(negedge clk);

        // One cycle longer: timeout inside XFER.
        sp_len = 19; sp_rx = 8'h44;
        v = vcyc.size(); pend1 = 1; req1 = 1;
        wait_valids(v + 1, "xfer timeout response");
        if (vcyc.size() > v) begin
            chk("xfer timeout err", 32'(verr[v]), 32'd1);
            chk("xfer timeout data", 32'(vdata[v]), 32'd0);
        end
        repeat (10) @(negedge clk);

        // Reset in XFER of requester 0 (so last winner is 0 before reset).
        sp_len = 16; sp_rx = 8'h3C; data0 = 8'hF0;
        v = vcyc.size(); pend0 = 1; req0 = 1;
        t = 0;
        while (!spi_busy && t < 100) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("rst gnt", 32'({gnt0, gnt1}), 32'd0);
        chk("rst valid/err", 32'({rsp_valid, rsp_err}), 32'd0);
        chk("rst ss/start", 32'({spi_ss, spi_start}), 32'h2);
        chk("rst data", 32'({rsp_id, rsp_data, spi_data}), 32'd0);
        rst = 0;
        repeat (30) @(negedge clk);
        chk("no response after reset", 32'(vcyc.size() - v), 32'd0);
        g = gq.size();
        data1 = 8'h66; pend0 = 1; pend1 = 1; req0 = 1; req1 = 1;
        wait_grants(g + 2, "post-reset grants");
        if (gq.size() >= g + 2) begin
            chk("post-reset first winner", 32'(gq[g]), 32'd0);
            chk("post-reset second winner", 32'(gq[g+1]), 32'd1);
        end
        repeat (30) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
